// File: rtl/mult_pkg.sv
// Shared codes for the sign-magnitude shift-and-add multiplier: datapath
// select encodings, controller state encoding and the state-to-output decode.
package mult_pkg;

    // A/B register select codes
    typedef enum logic [1:0] {
        SEL_LOAD  = 2'b00,
        SEL_SHR   = 2'b01,
        SEL_SHL   = 2'b10,
        SEL_STORE = 2'b11
    } sel_t;

    // Product register select codes
    typedef enum logic [1:0] {
        SC_STORE = 2'b00,
        SC_ACC   = 2'b01,
        SC_CLR   = 2'b10
    } sc_t;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ITER = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Bundle of every controller output so that a state maps to one value
    typedef struct packed {
        sel_t sa;
        sel_t sb;
        sc_t  sc;
        logic sneg;
        logic busy;
        logic done;
    } ctrl_out_t;

    // Moore decode: the output pattern that belongs to a given state
    function automatic ctrl_out_t decode_outputs(input state_t s);
        ctrl_out_t o;
        o.sa   = SEL_STORE;
        o.sb   = SEL_STORE;
        o.sc   = SC_STORE;
        o.sneg = 1'b0;
        o.busy = 1'b0;
        o.done = 1'b0;
        case (s)
            ST_LOAD: begin
                o.sa   = SEL_LOAD;
                o.sb   = SEL_LOAD;
                o.sc   = SC_CLR;
                o.sneg = 1'b1;
                o.busy = 1'b1;
            end
            ST_ITER: begin
                o.sa   = SEL_SHL;
                o.sb   = SEL_SHR;
                o.sc   = SC_ACC;
                o.busy = 1'b1;
            end
            ST_DONE: begin
                o.done = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier controller: synchronous clear,
// count enable, and a terminal-count flag on the final step.
module mult_iter_counter #(
    parameter int ITERS = 8,
    parameter int CNT_W = $clog2(ITERS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Count steps; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(ITERS - 1));

endmodule

// File: rtl/multiplier_controller.sv
// Sequencing FSM for the 8x8 shift-and-add multiplier: load/clear, one
// accumulate/shift step per multiplier bit, then hold done until acknowledged.
module multiplier_controller
    import mult_pkg::*;
#(
    parameter int ITERS = 8,
    parameter int CNT_W = $clog2(ITERS + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ack,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [1:0] SA,
    output logic [1:0] SB,
    output logic [1:0] SC,
    output logic       SNeg
);

    state_t           state;
    ctrl_out_t        outs;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             cnt_clr;
    logic             cnt_en;

    // Counter restarts on LOAD or abort, and stops advancing on its final step
    assign cnt_clr = abort || (state == ST_LOAD);
    assign cnt_en  = (state == ST_ITER) && !last;

    mult_iter_counter #(
        .ITERS (ITERS),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .last  (last)
    );

    // State register with outputs registered alongside the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            outs  <= decode_outputs(ST_IDLE);
        end else if (abort) begin
            state <= ST_IDLE;
            outs  <= decode_outputs(ST_IDLE);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        outs  <= decode_outputs(ST_LOAD);
                    end
                end
                ST_LOAD: begin
                    state <= ST_ITER;
                    outs  <= decode_outputs(ST_ITER);
                end
                ST_ITER: begin
                    if (last) begin
                        state <= ST_DONE;
                        outs  <= decode_outputs(ST_DONE);
                    end
                end
                ST_DONE: begin
                    if (ack && start) begin
                        state <= ST_LOAD;
                        outs  <= decode_outputs(ST_LOAD);
                    end else if (ack) begin
                        state <= ST_IDLE;
                        outs  <= decode_outputs(ST_IDLE);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    outs  <= decode_outputs(ST_IDLE);
                end
            endcase
        end
    end

    assign SA   = outs.sa;
    assign SB   = outs.sb;
    assign SC   = outs.sc;
    assign SNeg = outs.sneg;
    assign busy = outs.busy;
    assign done = outs.done;

endmodule

// File: tb/tb_multiplier_controller.sv
// Testbench for multiplier_controller with a behavioural multiplier datapath
// attached to the select lines; results are scoreboarded on each done edge.
module tb_multiplier_controller;

    localparam logic [8:0] V_IDLE = 9'b11_11_00_0_0_0;
    localparam logic [8:0] V_LOAD = 9'b00_00_10_1_1_0;
    localparam logic [8:0] V_ITER = 9'b10_01_01_0_1_0;
    localparam logic [8:0] V_DONE = 9'b11_11_00_0_0_1;
    localparam int         LATENCY = 9;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ack;
    logic       abort;
    logic       busy;
    logic       done;
    logic [1:0] SA;
    logic [1:0] SB;
    logic [1:0] SC;
    logic       SNeg;

    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [15:0] a_reg;
    logic [7:0]  b_reg;
    logic [15:0] prod;
    logic        is_neg;
    logic [8:0]  out_vec;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic done_prev = 1'b0;

    typedef struct {
        logic [15:0] prod;
        logic        neg;
        int          start_edge;
    } exp_t;

    exp_t sb_q[$];

    multiplier_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ack   (ack),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .SA    (SA),
        .SB    (SB),
        .SC    (SC),
        .SNeg  (SNeg)
    );

    assign out_vec = {SA, SB, SC, SNeg, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to measure start-to-done latency
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] mag(input logic [7:0] x);
        return x[7] ? (8'd0 - x) : x;
    endfunction

    // Behavioural datapath driven only by the controller select lines
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            prod   <= '0;
            is_neg <= 1'b0;
        end else begin
            case (SA)
                2'b00:   a_reg <= {8'd0, mag(in_a)};
                2'b01:   a_reg <= a_reg >> 1;
                2'b10:   a_reg <= a_reg << 1;
                default: ;
            endcase
            case (SB)
                2'b00:   b_reg <= mag(in_b);
                2'b01:   b_reg <= b_reg >> 1;
                2'b10:   b_reg <= b_reg << 1;
                default: ;
            endcase
            case (SC)
                2'b01:   if (b_reg[0]) prod <= prod + a_reg;
                2'b10:   prod <= '0;
                default: ;
            endcase
            if (SNeg)
                is_neg <= (in_a[7] ^ in_b[7]) && (in_a != 8'd0) && (in_b != 8'd0);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: on every rising done, pop the oldest expected result and compare
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done && !done_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no result at cycle %0d", cycle);
            end else begin
                e = sb_q.pop_front();
                check_output("product", 32'(prod), 32'(e.prod));
                check_output("is_neg", 32'(is_neg), 32'(e.neg));
                check_output("latency", 32'(cycle - e.start_edge), 32'(LATENCY));
            end
        end
        done_prev = done;
    end

    // Issue a start pulse at a negedge; optionally register the expected result
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                  input logic [15:0] exp_prod, input logic exp_neg,
                                  input bit expect_result);
        exp_t e;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        if (expect_result) begin
            e.prod       = exp_prod;
            e.neg        = exp_neg;
            e.start_edge = cycle + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check_output("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic ack_done();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_output("after_ack_idle", 32'(out_vec), 32'(V_IDLE));
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_prod, input logic exp_neg);
        apply_stimulus(a, b, exp_prod, exp_neg, 1'b1);
        wait_done(20);
        ack_done();
    endtask

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        abort = 1'b0;
        in_a  = '0;
        in_b  = '0;

        // Reset held for three cycles, then released
        repeat (3) @(negedge clk);
        check_output("in_reset", 32'(out_vec), 32'(V_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check_output("after_reset", 32'(out_vec), 32'(V_IDLE));

        // -3 * 5: check LOAD/ITER outputs, done hold, and release on ack
        apply_stimulus(8'hFD, 8'h05, 16'd15, 1'b1, 1'b1);
        check_output("load_outputs", 32'(out_vec), 32'(V_LOAD));
        @(negedge clk);
        check_output("iter_outputs", 32'(out_vec), 32'(V_ITER));
        wait_done(20);
        repeat (3) @(negedge clk);
        check_output("done_held", 32'(out_vec), 32'(V_DONE));
        ack_done();

        // Sign and zero cases
        run_op(8'h7F, 8'h81, 16'd16129, 1'b1);
        run_op(8'h00, 8'h80, 16'd0, 1'b0);

        // Back-to-back: start with ack in DONE goes straight to LOAD
        apply_stimulus(8'h05, 8'hFE, 16'd10, 1'b1, 1'b1);
        wait_done(20);
        in_a  = 8'd6;
        in_b  = 8'd7;
        start = 1'b1;
        ack   = 1'b1;
        begin
            exp_t e;
            e.prod       = 16'd42;
            e.neg        = 1'b0;
            e.start_edge = cycle + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
        check_output("b2b_load", 32'(out_vec), 32'(V_LOAD));
        wait_done(20);
        ack_done();

        // start pulses during ITER are ignored
        apply_stimulus(8'h0C, 8'h0B, 16'd132, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("iter_ignore_start", 32'(out_vec), 32'(V_ITER));
        wait_done(20);
        ack_done();

        // Abort in the ITER cycle with counter=3 (cycle 5)
        apply_stimulus(8'h09, 8'h09, 16'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_output("pre_abort_iter", 32'(out_vec), 32'(V_ITER));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("after_abort", 32'(out_vec), 32'(V_IDLE));
        repeat (12) @(negedge clk);
        check_output("abort_no_done", 32'(done), 32'd0);

        // Asynchronous reset while in LOAD
        apply_stimulus(8'h03, 8'h03, 16'd0, 1'b0, 1'b0);
        check_output("pre_reset_load", 32'(out_vec), 32'(V_LOAD));
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", 32'(out_vec), 32'(V_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh operation after abort and reset: -7 * -9
        run_op(8'hF9, 8'hF7, 16'd63, 1'b0);

        repeat (3) @(negedge clk);
        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_controller.md
# multiplier_controller

Sequencing FSM for the 8×8 sign-magnitude shift-and-add multiplier datapath. It accepts a start request and drives the datapath select lines in order: load and clear, then one accumulate/shift step per multiplier bit. It then raises done and holds it until the consumer acknowledges. It sits between the system-level requester and the multiplier datapath, and is the only driver of SA, SB, SC and SNeg.

## Interface
- ITERS, default 8: accumulate/shift steps per operation; must equal the operand width.
- CNT_W, default $clog2(ITERS+1): iteration counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled only in IDLE, or in DONE together with ack.
- ack  in  1  consumer acknowledge of done.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- busy  out  1  high in LOAD and ITER.
- done  out  1  high in DONE; product and IsNeg in the datapath are valid while it is high.
- SA  out  2  A-register select: 00 load, 01 shr, 10 shl, 11 store.
- SB  out  2  B-register select: same encoding as SA.
- SC  out  2  product select: 00 store, 01 acc, 10 clr.
- SNeg  out  1  sign-capture enable.
- Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- States are IDLE, LOAD, ITER and DONE. Outputs are Moore, decoded from state only.
- **IDLE**
  - Outputs: SA=11, SB=11, SC=00, SNeg=0, busy=0, done=0.
  - start=1 → LOAD.
- **LOAD**
  - Outputs: SA=00, SB=00, SC=10, SNeg=1, busy=1.
  - Clears the counter and moves to ITER unconditionally.
- **ITER**
  - Outputs: SA=10 (A shl), SB=01 (B shr), SC=01 (acc), SNeg=0, busy=1.
  - The accumulate uses the pre-shift A and B, so all three updates happen on the same edge.
  - The counter increments each cycle. When counter == ITERS-1 at an edge, go to DONE.
- **DONE**
  - Outputs: store codes (11/11/00), done=1, busy=0.
  - ack=1 and start=1 → LOAD (back-to-back operation).
  - ack=1 and start=0 → IDLE.
  - ack=0 → stay in DONE; product is held.
- **abort**
  - Has priority over start and ack in every state.
  - Next state is IDLE and the counter is cleared.
  - The datapath is left in store mode; partial product contents are don't-care.
- start outside IDLE/DONE is ignored. It is not queued.
- start held high in IDLE is accepted once per operation.

## Timing
- Reset values: state=IDLE, counter=0, busy=0, done=0, SA=11, SB=11, SC=00, SNeg=0.
- rst_n low mid-operation forces IDLE immediately. All outputs take their reset values asynchronously.
- Counting from the edge where start is sampled in IDLE (edge 0):
  - LOAD occupies cycle 1.
  - ITER occupies cycles 2..ITERS+1.
  - done rises after edge ITERS+1, which is cycle 10 for ITERS=8.
- Throughput with back-to-back start+ack in DONE: one result per ITERS+2 cycles.
- The sign flag is captured at the end of LOAD and is stable from cycle 2 onward.
- Counter wrap is not possible; the counter saturates at ITERS-1 by construction.

## Structure
- Shared package mult_pkg holds:
  - SA/SB codes: SEL_LOAD, SEL_SHR, SEL_SHL, SEL_STORE.
  - SC codes: SC_STORE, SC_ACC, SC_CLR.
  - State encoding: ST_IDLE, ST_LOAD, ST_ITER, ST_DONE.
- One natural sub-module: mult_iter_counter.
  - Clear/enable counter with async reset.
  - Terminal-count output last = (cnt == ITERS-1).
- Top level = FSM plus output decode plus the counter instance.
- A wrapper connecting the controller to the datapath is the integration test target.

## Test plan
- Reset: rst_n low for 3 cycles, then release → IDLE outputs (SA=11, SB=11, SC=00, SNeg=0, busy=0, done=0).
- InA=0xFD (-3), InB=5, start pulse at edge 0 → busy during cycles 1–9, done at cycle 10, product=15, IsNeg=1. done is held until ack, and leaves one cycle after ack.
- InA=0x7F, InB=0x81 → product=16129, IsNeg=1. Then InA=0, InB=0x80 → product=0, IsNeg=0.
- Back-to-back: start=1 and ack=1 in DONE → LOAD on the next cycle, no IDLE cycle. The second result (InA=6, InB=7 → 42) gives done 10 cycles after the first ack.
- start pulses during ITER → no effect; the cycle count and result are unchanged.
- abort in the ITER cycle at counter=3 → IDLE next cycle, done never asserts. Separately, rst_n low in LOAD → immediate reset outputs. A fresh start afterwards gives a correct product.
